// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial two's-complement subtractor: D = A - B, computed one bit per clock,
// LSB first, through a single full-subtractor cell with a registered borrow.
// The operands are captured on the edge that accepts a single-cycle START in
// IDLE. Bits are then processed for WIDTH cycles in RUN. Result, borrow and
// flags are published on entry to FIN together with a one-cycle DONE pulse.
//
// Ports
//   i_clk    : system clock, rising edge active
//   i_rst_n  : asynchronous active-low reset
//   i_start  : operation request, only honoured in IDLE
//   i_a      : minuend   [WIDTH-1:0], captured on the accept edge
//   i_b      : subtrahend[WIDTH-1:0], captured on the accept edge
//   o_busy   : high while bits are being processed (RUN)
//   o_done   : one-cycle pulse, results are final
//   o_d      : difference A - B modulo 2^WIDTH
//   o_bout   : final borrow (unsigned A < unsigned B)
//   o_ovf    : signed overflow of A - B
//   o_zero   : o_d == 0
//
// All outputs are registered. The result outputs only change on the edge that
// completes an operation (or on reset), so partial results are never visible.
// -----------------------------------------------------------------------------
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_d,
  output logic             o_bout,
  output logic             o_ovf,
  output logic             o_zero
);

  // Counter only needs to reach WIDTH-1; clog2 is enough for WIDTH >= 2.
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_sr;
  logic             r_bw;
  logic [CW-1:0]    r_cnt;
  logic             r_a_msb;
  logic             r_b_msb;

  logic             w_accept;
  logic             w_last;
  logic             w_a_bit;
  logic             w_b_bit;
  logic             w_d_bit;
  logic             w_bw_nxt;
  logic [WIDTH-1:0] w_sr_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;
  logic             w_publish;
  logic             w_ovf_nxt;
  logic             w_zero_nxt;

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic; FIN always falls back to IDLE after one cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (w_last) begin
          w_state_nxt = ST_FIN;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_FIN:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Full-subtractor cell on the current LSBs plus the running borrow.
  always_comb begin
    w_a_bit  = r_sa[0];
    w_b_bit  = r_sb[0];
    w_d_bit  = w_a_bit ^ w_b_bit ^ r_bw;
    w_bw_nxt = (~w_a_bit & w_b_bit) | (~w_a_bit & r_bw) | (w_b_bit & r_bw);
    w_sr_nxt = {w_d_bit, r_sr[WIDTH-1:1]};
    w_last   = (r_cnt == CNT_LAST);
    w_accept = (r_state == ST_IDLE) && i_start;
  end

  // FSM output logic: next values of the registered status/result outputs.
  // The result is taken from w_sr_nxt because the final bit is still being
  // produced on the edge that enters FIN.
  always_comb begin
    w_busy_nxt = (w_state_nxt == ST_RUN);
    w_done_nxt = (w_state_nxt == ST_FIN);
    w_publish  = (r_state == ST_RUN) && w_last;
    w_ovf_nxt  = (r_a_msb != r_b_msb) && (w_sr_nxt[WIDTH-1] != r_a_msb);
    w_zero_nxt = (w_sr_nxt == {WIDTH{1'b0}});
  end

  // Operand/result shift registers, borrow and bit counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sa    <= {WIDTH{1'b0}};
      r_sb    <= {WIDTH{1'b0}};
      r_sr    <= {WIDTH{1'b0}};
      r_bw    <= 1'b0;
      r_cnt   <= {CW{1'b0}};
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_sa    <= i_a;
            r_sb    <= i_b;
            r_bw    <= 1'b0;
            r_cnt   <= {CW{1'b0}};
            r_a_msb <= i_a[WIDTH-1];
            r_b_msb <= i_b[WIDTH-1];
          end else begin
            r_sa    <= r_sa;
            r_sb    <= r_sb;
            r_bw    <= r_bw;
            r_cnt   <= r_cnt;
            r_a_msb <= r_a_msb;
            r_b_msb <= r_b_msb;
          end
        end
        ST_RUN: begin
          r_sa  <= {1'b0, r_sa[WIDTH-1:1]};
          r_sb  <= {1'b0, r_sb[WIDTH-1:1]};
          r_sr  <= w_sr_nxt;
          r_bw  <= w_bw_nxt;
          r_cnt <= r_cnt + CW'(1);
        end
        default: begin
          r_sa  <= r_sa;
          r_sb  <= r_sb;
          r_sr  <= r_sr;
          r_bw  <= r_bw;
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

  // Registered outputs; result fields only update when an operation completes.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_busy <= 1'b0;
      o_done <= 1'b0;
      o_d    <= {WIDTH{1'b0}};
      o_bout <= 1'b0;
      o_ovf  <= 1'b0;
      o_zero <= 1'b0;
    end else begin
      o_busy <= w_busy_nxt;
      o_done <= w_done_nxt;
      if (w_publish) begin
        o_d    <= w_sr_nxt;
        o_bout <= w_bw_nxt;
        o_ovf  <= w_ovf_nxt;
        o_zero <= w_zero_nxt;
      end else begin
        o_d    <= o_d;
        o_bout <= o_bout;
        o_ovf  <= o_ovf;
        o_zero <= o_zero;
      end
    end
  end

endmodule
